// File: rtl/img_stream_tx_if.sv
// Bundle between img_stream_tx and its neighbours: the upstream pixel handshake
// and the frame-timed video stream handed to the line-buffer stages.
interface img_stream_tx_if;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        post_vs;
    logic        post_hs;
    logic        post_clken;
    logic [15:0] post_img_data;

    modport slave (
        input  s_data, s_valid,
        output s_ready, post_vs, post_hs, post_clken, post_img_data
    );

    modport master (
        output s_data, s_valid,
        input  s_ready, post_vs, post_hs, post_clken, post_img_data
    );
endinterface

// File: rtl/img_stream_tx.sv
// Video stream transmitter: drains upstream pixels into vs/hs/clken framing with programmable blanking.
// Optional macro TEST_PATTERN_EN replaces the upstream source with an internal coordinate pattern.
module img_stream_tx #(
    parameter int unsigned IMG_H   = 1280,
    parameter int unsigned IMG_V   = 720,
    parameter int unsigned H_BLANK = 160,
    parameter int unsigned V_BLANK = 30
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    img_stream_tx_if.slave  bus,
    output logic            underflow,
    output logic            frame_done
);
    localparam int unsigned CNT_W = 11;
    localparam int unsigned BLK_W = 16;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LEAD   = 3'd1;
    localparam logic [2:0] LINE   = 3'd2;
    localparam logic [2:0] HBLANK = 3'd3;
    localparam logic [2:0] VBLANK = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic [BLK_W-1:0] b_cnt;
    logic             xfer;
    logic             stall;
    logic             line_end;
    logic [15:0]      pix;

`ifdef TEST_PATTERN_EN
    assign bus.s_ready = 1'b0;
    assign xfer        = (state == LINE);
    assign stall       = 1'b0;
    assign pix         = {h_cnt[4:0], v_cnt[5:0], h_cnt[9:5]};
`else
    assign bus.s_ready = (state == LINE);
    assign xfer        = bus.s_valid && bus.s_ready;
    assign stall       = (state == LINE) && !bus.s_valid;
    assign pix         = bus.s_data;
`endif

    assign line_end = xfer && (h_cnt == CNT_W'(IMG_H - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; v_cnt already counts the line just finished while in HBLANK
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (enable) state_nxt = LEAD;
            LEAD:   if (b_cnt == BLK_W'(H_BLANK - 1)) state_nxt = LINE;
            LINE:   if (line_end) state_nxt = HBLANK;
            HBLANK: if (b_cnt == BLK_W'(H_BLANK - 1))
                        state_nxt = (v_cnt == CNT_W'(IMG_V)) ? VBLANK : LINE;
            VBLANK: if (b_cnt == BLK_W'(V_BLANK - 1))
                        state_nxt = enable ? LEAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counters: blanking timer restarts on every state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
            b_cnt <= '0;
        end else begin
            if (state_nxt != state)
                b_cnt <= '0;
            else if (state == LEAD || state == HBLANK || state == VBLANK)
                b_cnt <= b_cnt + BLK_W'(1);

            if (line_end)
                h_cnt <= '0;
            else if (xfer)
                h_cnt <= h_cnt + CNT_W'(1);

            if (line_end)
                v_cnt <= v_cnt + CNT_W'(1);
            else if (state == HBLANK && state_nxt == VBLANK)
                v_cnt <= '0;
        end
    end

    // Registered stream outputs, one cycle behind the state that produced them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.post_vs       <= 1'b0;
            bus.post_hs       <= 1'b0;
            bus.post_clken    <= 1'b0;
            bus.post_img_data <= '0;
            underflow         <= 1'b0;
            frame_done        <= 1'b0;
        end else begin
            bus.post_vs    <= (state == LEAD) || (state == LINE) || (state == HBLANK);
            bus.post_hs    <= (state == LINE);
            bus.post_clken <= xfer;
            underflow      <= stall;
            frame_done     <= (state == HBLANK) && (state_nxt == VBLANK);
            // Data holds between pixels inside a frame and parks at zero between frames
            if (xfer)
                bus.post_img_data <= pix;
            else if (state == IDLE || state == VBLANK)
                bus.post_img_data <= '0;
        end
    end
endmodule

// File: tb/tb_img_stream_tx.sv
// Bench for img_stream_tx: randomized upstream traffic, output trace checked against frame rules.
`timescale 1ns/1ps
module tb_img_stream_tx;
    localparam int unsigned IMG_H   = 4;
    localparam int unsigned IMG_V   = 2;
    localparam int unsigned H_BLANK = 3;
    localparam int unsigned V_BLANK = 5;

    typedef struct packed {
        logic        vs;
        logic        hs;
        logic        ck;
        logic        uf;
        logic        fd;
        logic [15:0] d;
    } smp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic enable;
    logic underflow;
    logic frame_done;
    logic last_rdy;
    logic rdy_seen;

    smp_t        trace[$];
    logic [15:0] sent[$];
    int          checks   = 0;
    int          failures = 0;

    img_stream_tx_if bus();

    img_stream_tx #(
        .IMG_H(IMG_H), .IMG_V(IMG_V), .H_BLANK(H_BLANK), .V_BLANK(V_BLANK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus),
        .underflow(underflow), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Sample outputs at the falling edge, then drive the next upstream beat
    task automatic cycle(input bit v, input logic [15:0] d);
        smp_t s;
        @(negedge clk);
        s.vs = bus.post_vs; s.hs = bus.post_hs; s.ck = bus.post_clken;
        s.uf = underflow;   s.fd = frame_done;  s.d  = bus.post_img_data;
        trace.push_back(s);
        last_rdy = bus.s_ready;
        if (bus.s_ready) rdy_seen = 1'b1;
        if (v && bus.s_ready) sent.push_back(d);
        bus.s_valid = v;
        bus.s_data  = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        trace.delete(); sent.delete(); rdy_seen = 1'b0;
    endtask

    function automatic int count_of(input int sel);
        int n = 0;
        foreach (trace[i]) begin
            case (sel)
                0: n += int'(trace[i].ck);
                1: n += int'(trace[i].uf);
                2: n += int'(trace[i].fd);
                default: n += int'(trace[i].vs && (i == 0 || !trace[i-1].vs));
            endcase
        end
        return n;
    endfunction

    function automatic int first_of(input bit hs_sel);
        foreach (trace[i]) if (hs_sel ? trace[i].hs : trace[i].vs) return i;
        return -1;
    endfunction

    function automatic int first_hs_run();
        int n = 0;
        int i = first_of(1'b1);
        if (i < 0) return 0;
        while (i < trace.size() && trace[i].hs) begin n++; i++; end
        return n;
    endfunction

    // Pixels leave in acceptance order, none lost or repeated
    function automatic int data_errors();
        int k = 0, bad = 0;
        foreach (trace[i]) if (trace[i].ck) begin
            if (k >= sent.size() || trace[i].d !== sent[k]) bad++;
            k++;
        end
        return bad;
    endfunction

    // Frame rules: lead-in and line gaps of H_BLANK, IMG_H pixels per line, IMG_V lines per frame,
    // frame_done on the last vs-high cycle, vs low at least V_BLANK, underflow only on empty line cycles
    function automatic int frame_violations();
        int   bad = 0, lines = 0, quiet = 0, ck_run = 0, vs_lo = 0;
        bit   framed = 1'b0;
        smp_t p = '0;
        smp_t c;
        foreach (trace[i]) begin
            c = trace[i];
            if ((c.hs && !c.vs) || (c.ck && !c.hs)) bad++;
            if (c.uf !== (c.hs && !c.ck)) bad++;
            if (c.vs && !p.vs) begin
                if (framed && vs_lo < int'(V_BLANK)) bad++;
                lines = 0; quiet = 0; framed = 1'b1;
            end
            vs_lo = c.vs ? 0 : vs_lo + 1;
            if (c.hs && !p.hs && quiet != int'(H_BLANK)) bad++;
            if (p.hs && !c.hs) begin
                if (ck_run != int'(IMG_H)) bad++;
                lines++; ck_run = 0;
            end
            if (c.ck) ck_run++;
            quiet = (c.vs && !c.hs) ? quiet + 1 : 0;
            if (c.fd !== (c.vs && !c.hs && lines == int'(IMG_V) && quiet == int'(H_BLANK))) bad++;
            if (p.vs && !c.vs && !(p.fd && lines == int'(IMG_V))) bad++;
            p = c;
        end
        return bad;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; bus.s_valid = 1'b1; bus.s_data = 16'hffff;
        repeat (3) @(negedge clk);
        checks++; if (bus.post_vs !== 1'b0) begin failures++; $display("FAIL reset_vs got=%b exp=0", bus.post_vs); end
        checks++; if (bus.post_hs !== 1'b0) begin failures++; $display("FAIL reset_hs got=%b exp=0", bus.post_hs); end
        checks++; if (bus.post_clken !== 1'b0) begin failures++; $display("FAIL reset_clken got=%b exp=0", bus.post_clken); end
        checks++; if (bus.post_img_data !== 16'h0) begin failures++; $display("FAIL reset_data got=%h exp=0000", bus.post_img_data); end
        checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.s_ready); end
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    endtask

`ifdef TEST_PATTERN_EN
    task automatic test_pattern();
        logic [15:0] out[$];
        int bad = 0;
        do_reset();
        for (int i = 0; i < 50; i++) begin
            enable = (i < 5);
            cycle($urandom_range(0, 1) == 1, 16'($urandom));
        end
        foreach (trace[i]) if (trace[i].ck) out.push_back(trace[i].d);
        checks++;
        if (out.size() != int'(IMG_H * IMG_V)) begin failures++; $display("FAIL pat_count got=%0d exp=%0d", out.size(), IMG_H * IMG_V); end
        foreach (out[k]) begin
            int h = k % int'(IMG_H);
            int l = k / int'(IMG_H);
            if (out[k] !== 16'(((h % 32) << 11) | ((l % 64) << 5) | ((h / 32) % 32))) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL pat_data got=%0d bad exp=0", bad); end
        checks++;
        if (out.size() < 8 || out[7] !== 16'h1820) begin failures++; $display("FAIL pat_l1p3 got=%h exp=1820", out.size() < 8 ? 16'h0 : out[7]); end
        checks++; if (count_of(1) != 0) begin failures++; $display("FAIL pat_underflow got=%0d exp=0", count_of(1)); end
        checks++; if (rdy_seen !== 1'b0) begin failures++; $display("FAIL pat_ready got=%b exp=0", rdy_seen); end
        checks++; if (frame_violations() != 0) begin failures++; $display("FAIL pat_framing got=%0d exp=0", frame_violations()); end
    endtask
`else
    task automatic test_frames();
        int lead;
        do_reset();
        for (int i = 0; i < 70; i++) begin
            enable = (i < 30);
            cycle(1'b1, 16'(sent.size() + 1));
        end
        lead = first_of(1'b1) - first_of(1'b0);
        checks++; if (lead != int'(H_BLANK)) begin failures++; $display("FAIL frames_lead got=%0d exp=%0d", lead, H_BLANK); end
        checks++; if (count_of(0) != int'(2 * IMG_H * IMG_V)) begin failures++; $display("FAIL frames_pixels got=%0d exp=%0d", count_of(0), 2 * IMG_H * IMG_V); end
        checks++; if (data_errors() != 0) begin failures++; $display("FAIL frames_data got=%0d bad exp=0", data_errors()); end
        checks++; if (count_of(2) != 2) begin failures++; $display("FAIL frames_done got=%0d exp=2", count_of(2)); end
        checks++; if (count_of(1) != 0) begin failures++; $display("FAIL frames_underflow got=%0d exp=0", count_of(1)); end
        checks++; if (frame_violations() != 0) begin failures++; $display("FAIL frames_framing got=%0d exp=0", frame_violations()); end
    endtask

    task automatic test_stall();
        int  stall = 2;
        bit  v;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            enable = (i < 5);
            v = 1'b1;
            if (sent.size() == 2 && stall > 0) begin v = 1'b0; stall--; end
            cycle(v, 16'(sent.size() + 1));
        end
        checks++; if (count_of(1) != 2) begin failures++; $display("FAIL stall_underflow got=%0d exp=2", count_of(1)); end
        checks++; if (first_hs_run() != int'(IMG_H) + 2) begin failures++; $display("FAIL stall_hs_len got=%0d exp=%0d", first_hs_run(), IMG_H + 2); end
        checks++; if (count_of(0) != int'(IMG_H * IMG_V)) begin failures++; $display("FAIL stall_pixels got=%0d exp=%0d", count_of(0), IMG_H * IMG_V); end
        checks++; if (data_errors() != 0) begin failures++; $display("FAIL stall_data got=%0d bad exp=0", data_errors()); end
        checks++; if (frame_violations() != 0) begin failures++; $display("FAIL stall_framing got=%0d exp=0", frame_violations()); end
    endtask

    task automatic test_enable_drop();
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (sent.size() >= int'(IMG_H) + 1) enable = 1'b0;
            cycle($urandom_range(0, 99) < 70, 16'($urandom));
        end
        checks++; if (count_of(3) != 1) begin failures++; $display("FAIL drop_frames got=%0d exp=1", count_of(3)); end
        checks++; if (count_of(2) != 1) begin failures++; $display("FAIL drop_done got=%0d exp=1", count_of(2)); end
        checks++; if (count_of(0) != int'(IMG_H * IMG_V)) begin failures++; $display("FAIL drop_pixels got=%0d exp=%0d", count_of(0), IMG_H * IMG_V); end
        checks++; if (data_errors() != 0) begin failures++; $display("FAIL drop_data got=%0d bad exp=0", data_errors()); end
        checks++; if (frame_violations() != 0) begin failures++; $display("FAIL drop_framing got=%0d exp=0", frame_violations()); end
        @(negedge clk);
        checks++;
        if ({bus.post_vs, bus.post_hs, bus.post_clken, underflow, frame_done, bus.s_ready} !== 6'b0 || bus.post_img_data !== 16'h0) begin
            failures++;
            $display("FAIL drop_idle got=%b/%h exp=000000/0000",
                     {bus.post_vs, bus.post_hs, bus.post_clken, underflow, frame_done, bus.s_ready}, bus.post_img_data);
        end
    endtask

    task automatic test_reset_mid();
        int lead;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 40 && sent.size() < 2; i++) cycle(1'b1, 16'(sent.size() + 1));
        checks++; if (sent.size() != 2) begin failures++; $display("FAIL rmid_reach got=%0d exp=2", sent.size()); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.post_vs, bus.post_hs, bus.post_clken, underflow, frame_done, bus.s_ready} !== 6'b0 || bus.post_img_data !== 16'h0) begin
            failures++;
            $display("FAIL rmid_clear got=%b/%h exp=000000/0000",
                     {bus.post_vs, bus.post_hs, bus.post_clken, underflow, frame_done, bus.s_ready}, bus.post_img_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        trace.delete(); sent.delete();
        for (int i = 0; i < 50; i++) begin
            enable = (i < 8);
            cycle(1'b1, 16'(sent.size() + 1));
        end
        lead = first_of(1'b1) - first_of(1'b0);
        checks++; if (lead != int'(H_BLANK)) begin failures++; $display("FAIL rmid_lead got=%0d exp=%0d", lead, H_BLANK); end
        checks++; if (count_of(0) != int'(IMG_H * IMG_V)) begin failures++; $display("FAIL rmid_pixels got=%0d exp=%0d", count_of(0), IMG_H * IMG_V); end
        checks++; if (data_errors() != 0) begin failures++; $display("FAIL rmid_data got=%0d bad exp=0", data_errors()); end
        checks++; if (frame_violations() != 0) begin failures++; $display("FAIL rmid_framing got=%0d exp=0", frame_violations()); end
    endtask

    task automatic test_line_stall();
        int stalls = 0;
        int waited = 0;
        bit v;
        do_reset();
        enable = 1'b1;
        last_rdy = 1'b0;
        while (!last_rdy && waited < 20) begin
            cycle(1'b0, 16'h0);
            waited++;
            if (last_rdy) stalls++;
        end
        checks++; if (last_rdy !== 1'b1) begin failures++; $display("FAIL lstall_reach got=%b exp=1", last_rdy); end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 16'h0);
            stalls++;
            checks++; if (last_rdy !== 1'b1) begin failures++; $display("FAIL lstall_ready got=%b exp=1", last_rdy); end
        end
        for (int i = 0; i < 160; i++) begin
            enable = (i < 90);
            v = $urandom_range(0, 99) < 60;
            cycle(v, 16'($urandom));
            if (!v && last_rdy) stalls++;
        end
        checks++; if (count_of(1) != stalls) begin failures++; $display("FAIL lstall_underflow got=%0d exp=%0d", count_of(1), stalls); end
        checks++; if (count_of(0) != sent.size()) begin failures++; $display("FAIL lstall_pixels got=%0d exp=%0d", count_of(0), sent.size()); end
        checks++; if (sent.size() % int'(IMG_H * IMG_V) != 0) begin failures++; $display("FAIL lstall_whole got=%0d exp=0", sent.size() % int'(IMG_H * IMG_V)); end
        checks++; if (data_errors() != 0) begin failures++; $display("FAIL lstall_data got=%0d bad exp=0", data_errors()); end
        checks++; if (frame_violations() != 0) begin failures++; $display("FAIL lstall_framing got=%0d exp=0", frame_violations()); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        last_rdy = 1'b0;
        rdy_seen = 1'b0;
        test_reset();
`ifdef TEST_PATTERN_EN
        test_pattern();
`else
        test_frames();
        test_stall();
        test_enable_drop();
        test_reset_mid();
        test_line_stall();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
